// File: rtl/prio_enc_rr_reg.sv
// Registered N-input priority encoder with fixed-MSB or round-robin priority.
// The result sits in an output register behind a valid/ready handshake.
module prio_enc_rr_reg #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_none,
   output logic [W-1:0] rr_ptr
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // The producer holds data stable while valid && !ready; in_ready does not
   // depend on in_valid, and out_valid never waits on out_ready.
   logic         accept;
   logic         consume;
   logic         res_mode;
   logic [W-1:0] ptr_next;
   logic [W-1:0] idx_lo;
   logic [W-1:0] idx_hi;
   logic         any_lo;
   logic [W-1:0] enc_idx;
   logic         enc_none;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   // Next pointer is also the pointer used to encode a vector accepted this
   // cycle, so a back-to-back mode-1 vector sees the grant being consumed now.
   always_comb begin
      ptr_next = rr_ptr;
      if (consume && res_mode && !out_none)
         ptr_next = (out_idx == '0) ? LAST : out_idx - W'(1);
   end

   // Indices at or below the start pointer outrank those above it; within each
   // group the highest index wins. Mode 0 puts every index in the first group.
   always_comb begin
      idx_lo   = '0;
      idx_hi   = '0;
      any_lo   = 1'b0;
      enc_none = (in_req == '0);
      for (int i = 0; i < N; i++) begin
         if (in_req[i]) begin
            if (!in_mode || (W'(i) <= ptr_next)) begin
               idx_lo = W'(i);
               any_lo = 1'b1;
            end else begin
               idx_hi = W'(i);
            end
         end
      end
      enc_idx = any_lo ? idx_lo : idx_hi;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_none  <= 1'b0;
         res_mode  <= 1'b0;
         rr_ptr    <= LAST;
      end else begin
         rr_ptr <= ptr_next;
         if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= enc_idx;
            out_none  <= enc_none;
            res_mode  <= in_mode;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
